// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - data-memory access controller with per-op write delay line
//
// Purpose: sits between ins_decoder, sprf_wrapper and dat_ram. Decoder dst ops are
// carried through a delay line so that each write lines up with its operand result.
// Src reads share the single dat_ram port and yield to the delay line.
//
// Ports:
//   clk, reset_b                      clock, asynchronous active-low reset
//   t_cs                              pipeline advance enable (0 freezes all state)
//   src_en_b, src_addr, src_ready     decoder read request / accept
//   dst_en_b, dst_rw, dst_addr,
//   dst_dly                           decoder dst request and its delay
//   amode, sprf_addr, sprf_step       addressing mode and pointer from sprf_wrapper
//   ptr_upd_vld, ptr_upd_addr         post-increment pointer write-back
//   dram_en_b, dram_rw, dram_addr     dat_ram port
module dmem_access_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int MAX_DLY = 4,
  parameter int DLY_W   = 3,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              t_cs,
  input  logic              src_en_b,
  input  logic [ADDR_W-1:0] src_addr,
  output logic              src_ready,
  input  logic              dst_en_b,
  input  logic              dst_rw,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [DLY_W-1:0]  dst_dly,
  input  logic [1:0]        amode,
  input  logic [ADDR_W-1:0] sprf_addr,
  input  logic [STEP_W-1:0] sprf_step,
  output logic              ptr_upd_vld,
  output logic [ADDR_W-1:0] ptr_upd_addr,
  output logic              dram_en_b,
  output logic              dram_rw,
  output logic [ADDR_W-1:0] dram_addr
);

  // Matured entries that lose arbitration keep shifting, so the line is longer than
  // MAX_DLY to give a backlog somewhere to live.
  localparam int NST   = 2 * MAX_DLY + 2;
  localparam int REM_W = DLY_W + 1;

  // rem counts the cycles still to wait; an entry issues in the cycle rem reaches 0.
  typedef struct packed {
    logic              vld;
    logic              rw;
    logic              pinc;
    logic [STEP_W-1:0] step;
    logic [REM_W-1:0]  rem;
    logic [ADDR_W-1:0] addr;
  } ent_t;

  localparam ent_t ENT_RST = '{vld: 1'b0, rw: 1'b1, pinc: 1'b0, step: '0, rem: '0, addr: '0};

  ent_t st_q [1:NST];
  ent_t cur  [0:NST];   // cur[0] is the incoming request, cur[k] is stage k

  logic              pend_vld;
  logic              pend_pinc;
  logic [STEP_W-1:0] pend_step;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W-1:0] last_ptr_q;

  logic              indir;
  logic [DLY_W-1:0]  dly_c;
  logic              line_hit;
  int                line_sel;
  logic              line_go, pend_go, src_acc, src_go, pend_load;
  logic              iss_vld, iss_rw, iss_pinc;
  logic [STEP_W-1:0] iss_step;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] ptr_nxt;

  function automatic ent_t age(input ent_t e);
    ent_t r;
    if (!e.vld) begin
      r = ENT_RST;
    end else begin
      r = e;
      if (e.rem != '0) r.rem = e.rem - REM_W'(1);
    end
    return r;
  endfunction

  assign indir = (amode == 2'd1) || (amode == 2'd2);
  assign dly_c = (dst_dly > DLY_W'(MAX_DLY)) ? DLY_W'(MAX_DLY) : dst_dly;

  // The pointer is latched into the entry, which costs indirect ops one extra cycle.
  always_comb begin
    cur[0]      = ENT_RST;
    cur[0].vld  = ~dst_en_b;
    cur[0].rw   = dst_rw;
    cur[0].pinc = (amode == 2'd2);
    cur[0].step = sprf_step;
    cur[0].addr = indir ? sprf_addr : dst_addr;
    cur[0].rem  = REM_W'(dly_c) + REM_W'(indir);
    for (int k = 1; k <= NST; k++) cur[k] = st_q[k];
  end

  // Highest stage index is the oldest entry; it wins among matured ones.
  always_comb begin
    line_hit = 1'b0;
    line_sel = 0;
    for (int k = 0; k <= NST; k++) begin
      if (cur[k].vld && (cur[k].rem == '0)) begin
        line_hit = 1'b1;
        line_sel = k;
      end
    end
  end

  assign line_go   = t_cs & line_hit;
  assign pend_go   = t_cs & pend_vld & ~line_hit;
  assign src_acc   = t_cs & ~src_en_b & ~pend_vld;
  assign src_go    = src_acc & ~indir & ~line_hit;
  // Indirect src reads always take the buffer, which gives them the pointer-latch cycle.
  assign pend_load = src_acc & (indir | line_hit);

  always_comb begin
    iss_vld  = 1'b0;
    iss_rw   = 1'b1;
    iss_pinc = 1'b0;
    iss_step = '0;
    iss_addr = last_addr_q;
    if (line_go) begin
      iss_vld  = 1'b1;
      iss_rw   = cur[line_sel].rw;
      iss_pinc = cur[line_sel].pinc;
      iss_step = cur[line_sel].step;
      iss_addr = cur[line_sel].addr;
    end else if (pend_go) begin
      iss_vld  = 1'b1;
      iss_pinc = pend_pinc;
      iss_step = pend_step;
      iss_addr = pend_addr;
    end else if (src_go) begin
      iss_vld  = 1'b1;
      iss_addr = src_addr;
    end
  end

  assign ptr_nxt      = iss_addr + ADDR_W'(iss_step);
  assign dram_en_b    = ~iss_vld;
  assign dram_rw      = iss_rw;
  assign dram_addr    = iss_addr;
  assign ptr_upd_vld  = iss_vld & iss_pinc;
  assign ptr_upd_addr = ptr_upd_vld ? ptr_nxt : last_ptr_q;
  assign src_ready    = ~pend_vld;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int k = 1; k <= NST; k++) st_q[k] <= ENT_RST;
      pend_vld    <= 1'b0;
      pend_pinc   <= 1'b0;
      pend_step   <= '0;
      pend_addr   <= '0;
      last_addr_q <= '0;
      last_ptr_q  <= '0;
    end else if (t_cs) begin
      for (int k = 0; k < NST; k++) begin
        st_q[k+1] <= (line_hit && (line_sel == k)) ? ENT_RST : age(cur[k]);
      end
      if (pend_go) begin
        pend_vld <= 1'b0;
      end else if (pend_load) begin
        pend_vld  <= 1'b1;
        pend_pinc <= (amode == 2'd2);
        pend_step <= sprf_step;
        pend_addr <= indir ? sprf_addr : src_addr;
      end
      if (iss_vld) last_addr_q <= iss_addr;
      if (ptr_upd_vld) last_ptr_q <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       t_cs = 1'b1;
  logic       src_en_b = 1'b1;
  logic [9:0] src_addr = '0;
  logic       src_ready;
  logic       dst_en_b = 1'b1;
  logic       dst_rw = 1'b0;
  logic [9:0] dst_addr = '0;
  logic [2:0] dst_dly = '0;
  logic [1:0] amode = '0;
  logic [9:0] sprf_addr = '0;
  logic [3:0] sprf_step = '0;
  logic       ptr_upd_vld;
  logic [9:0] ptr_upd_addr;
  logic       dram_en_b;
  logic       dram_rw;
  logic [9:0] dram_addr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic       rw;
    logic [9:0] addr;
    logic       pinc;
    logic [9:0] ptr;
  } exp_t;
  exp_t sb[$];

  dmem_access_ctrl dut (
    .clk(clk), .reset_b(reset_b), .t_cs(t_cs),
    .src_en_b(src_en_b), .src_addr(src_addr), .src_ready(src_ready),
    .dst_en_b(dst_en_b), .dst_rw(dst_rw), .dst_addr(dst_addr), .dst_dly(dst_dly),
    .amode(amode), .sprf_addr(sprf_addr), .sprf_step(sprf_step),
    .ptr_upd_vld(ptr_upd_vld), .ptr_upd_addr(ptr_upd_addr),
    .dram_en_b(dram_en_b), .dram_rw(dram_rw), .dram_addr(dram_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src_en_b = 1'b1;
    dst_en_b = 1'b1;
    amode    = 2'd0;
    t_cs     = 1'b1;
  endtask

  task automatic expect_issue(input int c, input logic rw, input logic [9:0] a,
                              input logic pinc, input logic [9:0] ptr);
    exp_t e;
    e.cyc = c; e.rw = rw; e.addr = a; e.pinc = pinc; e.ptr = ptr;
    sb.push_back(e);
  endtask

  task automatic dst_op(input logic rw, input logic [9:0] a, input logic [2:0] d,
                        input logic [1:0] m);
    dst_en_b = 1'b0; dst_rw = rw; dst_addr = a; dst_dly = d; amode = m;
  endtask

  task automatic check_reset_outputs();
    chk("rst_dram_en_b", 32'(dram_en_b), 32'd1);
    chk("rst_dram_rw", 32'(dram_rw), 32'd1);
    chk("rst_dram_addr", 32'(dram_addr), 32'd0);
    chk("rst_ptr_upd_vld", 32'(ptr_upd_vld), 32'd0);
    chk("rst_ptr_upd_addr", 32'(ptr_upd_addr), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd1);
  endtask

  // Monitor: every dat_ram access is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset_b) begin
      if (!dram_en_b) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got addr 0x%0h rw %0b expected no access (cycle %0d)",
                   dram_addr, dram_rw, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("issue_cycle", 32'(cyc), 32'(e.cyc));
          chk("issue_addr", 32'(dram_addr), 32'(e.addr));
          chk("issue_rw", 32'(dram_rw), 32'(e.rw));
          chk("issue_ptr_vld", 32'(ptr_upd_vld), 32'(e.pinc));
          if (e.pinc) chk("issue_ptr_addr", 32'(ptr_upd_addr), 32'(e.ptr));
        end
      end
      if (!t_cs) begin
        chk("stall_ptr_vld", 32'(ptr_upd_vld), 32'd0);
        chk("stall_dram_en_b", 32'(dram_en_b), 32'd1);
      end
    end
  end

  initial begin
    int c;
    #3;
    check_reset_outputs();
    step(); step();
    reset_b = 1'b1;
    step();

    // Delay: 2, 0, MAX, and an over-range value clamped to MAX
    c = cyc; dst_op(1'b0, 10'h123, 3'd2, 2'd0); expect_issue(c + 2, 1'b0, 10'h123, 1'b0, 10'h0);
    step(); idle(); repeat (6) step();
    c = cyc; dst_op(1'b0, 10'h1A5, 3'd0, 2'd0); expect_issue(c, 1'b0, 10'h1A5, 1'b0, 10'h0);
    step(); idle(); repeat (6) step();
    c = cyc; dst_op(1'b0, 10'h2B7, 3'd4, 2'd0); expect_issue(c + 4, 1'b0, 10'h2B7, 1'b0, 10'h0);
    step(); idle(); repeat (7) step();
    c = cyc; dst_op(1'b0, 10'h0F0, 3'd7, 2'd0); expect_issue(c + 4, 1'b0, 10'h0F0, 1'b0, 10'h0);
    step(); idle(); repeat (7) step();
    chk("idle_addr_hold", 32'(dram_addr), 32'h0F0);

    // Stall: three frozen cycles mid-delay slip the issue by three
    c = cyc; dst_op(1'b0, 10'h123, 3'd2, 2'd0); expect_issue(c + 5, 1'b0, 10'h123, 1'b0, 10'h0);
    step(); idle(); t_cs = 1'b0;
    repeat (3) step();
    t_cs = 1'b1;
    repeat (7) step();

    // Plain direct src read issues in the request cycle
    c = cyc; src_en_b = 1'b0; src_addr = 10'h0AB; expect_issue(c, 1'b1, 10'h0AB, 1'b0, 10'h0);
    step(); idle(); repeat (3) step();

    // Collision: maturing write beats a src read, read follows next cycle
    c = cyc; dst_op(1'b0, 10'h010, 3'd2, 2'd0);
    step(); idle(); step();
    chk("coll_ready_before", 32'(src_ready), 32'd1);
    src_en_b = 1'b0; src_addr = 10'h020;
    expect_issue(c + 2, 1'b0, 10'h010, 1'b0, 10'h0);
    expect_issue(c + 3, 1'b1, 10'h020, 1'b0, 10'h0);
    step(); idle();
    chk("coll_ready_busy", 32'(src_ready), 32'd0);
    step();
    chk("coll_ready_after", 32'(src_ready), 32'd1);
    repeat (4) step();

    // Post-increment with wrap, src and dst paths; plain indirect; reserved mode
    sprf_addr = 10'h3FE; sprf_step = 4'd3;
    c = cyc; amode = 2'd2; src_en_b = 1'b0; expect_issue(c + 1, 1'b1, 10'h3FE, 1'b1, 10'h001);
    step(); idle(); repeat (4) step();
    c = cyc; dst_op(1'b0, 10'h000, 3'd1, 2'd2); expect_issue(c + 2, 1'b0, 10'h3FE, 1'b1, 10'h001);
    step(); idle(); repeat (5) step();
    sprf_addr = 10'h200;
    c = cyc; dst_op(1'b0, 10'h000, 3'd0, 2'd1); expect_issue(c + 1, 1'b0, 10'h200, 1'b0, 10'h0);
    step(); idle(); repeat (4) step();
    c = cyc; dst_op(1'b0, 10'h301, 3'd1, 2'd3); expect_issue(c + 1, 1'b0, 10'h301, 1'b0, 10'h0);
    step(); idle(); repeat (4) step();
    chk("ptr_addr_hold", 32'(ptr_upd_addr), 32'h001);

    // Ordering: older (dly 3) and younger (dly 1) writes mature together
    c = cyc; dst_op(1'b0, 10'h111, 3'd3, 2'd0);
    step(); idle(); step();
    dst_op(1'b0, 10'h222, 3'd1, 2'd0);
    expect_issue(c + 3, 1'b0, 10'h111, 1'b0, 10'h0);
    expect_issue(c + 4, 1'b0, 10'h222, 1'b0, 10'h0);
    step(); idle(); repeat (6) step();

    // Reset mid-traffic: queued write 0x055 and pending read 0x066 must vanish
    dst_op(1'b0, 10'h055, 3'd4, 2'd0);
    step();
    c = cyc; dst_op(1'b0, 10'h044, 3'd0, 2'd0); src_en_b = 1'b0; src_addr = 10'h066;
    expect_issue(c, 1'b0, 10'h044, 1'b0, 10'h0);
    step(); idle();
    reset_b = 1'b0;
    #2;
    check_reset_outputs();
    step();
    reset_b = 1'b1;
    repeat (10) step();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
